// File: rtl/regfile_mp.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
// Optional macro RF_BYPASS_EN adds write-through forwarding on every read port.
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter int SP_IDX  = 2,
    parameter     SP_INIT = 32'h2ffc,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rs_addr,
    output logic [NRD*XLEN-1:0]   rs_data,
    output logic [NRD-1:0]        rs_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_addr,
    output logic [NREGS-1:0]      busy_vec
);

    localparam logic [XLEN-1:0] SP_RESET = XLEN'(SP_INIT);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Alloc is applied after the write-clear so a same-cycle re-allocation wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (alloc_en) begin
            busy_d[alloc_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rs_addr[k*AW +: AW];
`ifdef RF_BYPASS_EN
        logic hit;
        assign hit = wr_en && (wr_addr != '0) && (addr == wr_addr);
        assign rs_data[k*XLEN +: XLEN] = (addr == '0) ? '0 : (hit ? wr_data : regs_q[addr]);
        assign rs_busy[k] = hit ? (alloc_en && (alloc_addr == wr_addr)) : busy_q[addr];
`else
        assign rs_data[k*XLEN +: XLEN] = (addr == '0) ? '0 : regs_q[addr];
        assign rs_busy[k] = busy_q[addr];
`endif
    end

endmodule
